// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES core.
// Everything here is pure combinational function logic. The round datapath
// is built from these functions, and the S-box is computed as a field
// inverse followed by the affine map, so no lookup ROM is needed.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int MAX_NR  = 14;
    localparam int KEYS_W  = BLOCK_W * (MAX_NR + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    function automatic int nr(input int nk);
        return nk + 6;
    endfunction

    // The schedule is left-aligned in a max-size vector, so round r is always
    // the r-th 128-bit slice counted from the MSB, whatever the key length.
    function automatic logic [BLOCK_W-1:0] key_slice(input logic [KEYS_W-1:0] keys,
                                                     input logic [3:0] r);
        return keys[KEYS_W-1-BLOCK_W*int'(r) -: BLOCK_W];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // a^254 = a^-1 for a != 0, and 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        for (int i = 0; i < 16; i++) o[BLOCK_W-1-8*i -: 8] = sbox(s[BLOCK_W-1-8*i -: 8]);
        return o;
    endfunction

    // Byte index is row + 4*col; row r rotates left by r columns.
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[BLOCK_W-1-8*(r+4*c) -: 8] = s[BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[BLOCK_W-1-32*c -: 8];
            a1 = s[BLOCK_W-9-32*c -: 8];
            a2 = s[BLOCK_W-17-32*c -: 8];
            a3 = s[BLOCK_W-25-32*c -: 8];
            o[BLOCK_W-1-32*c  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[BLOCK_W-9-32*c  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[BLOCK_W-17-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[BLOCK_W-25-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] add_round_key(input logic [BLOCK_W-1:0] s,
                                                         input logic [BLOCK_W-1:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_round_sel.sv
// One AES encryption round, combinational.
//   state_in  : current cipher state
//   round_key : key for this round
//   last      : 1 selects the final round (no MixColumns)
//   state_out : state after the round
module aes_round_sel
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last,
    output logic [BLOCK_W-1:0] state_out
);

    logic [BLOCK_W-1:0] sb;
    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] mc;

    always_comb begin
        sb        = sub_bytes(state_in);
        sr        = shift_rows(sb);
        mc        = mix_columns(sr);
        state_out = add_round_key(last ? sr : mc, round_key);
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock, valid/ready on both sides.
//   NK        : key length in 32-bit words (4, 6 or 8)
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready / in_block    : plaintext handshake
//   w         : expanded key schedule, round-0 key at the MSBs; held stable
//               from accept until the output handshake
//   out_valid / out_ready / out_block : ciphertext handshake
//   busy      : high while rounds are being computed
//
// state | meaning
// IDLE  | waiting for a plaintext block
// RUN   | computing rounds 1..NR, rnd holds the round being applied
// DONE  | ciphertext presented, waiting for out_ready
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BLOCK_W-1:0]         in_block,
    input  logic [BLOCK_W*(NK+7)-1:0]  w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_W-1:0]         out_block,
    output logic                       busy
);

    localparam int NR = nr(NK);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_cipher_iter: NK must be 4, 6 or 8");
    end

    fsm_t               fsm, fsm_d;
    logic [3:0]         rnd, rnd_d;
    logic [BLOCK_W-1:0] blk, blk_d;
    logic [KEYS_W-1:0]  keys;
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;
    logic               last_round;
    logic               accept;

    always_comb begin
        keys = '0;
        keys[KEYS_W-1 -: BLOCK_W*(NR+1)] = w;
    end

    assign round_key  = key_slice(keys, rnd);
    assign last_round = (rnd == 4'(NR));

    // Ready in DONE follows out_ready combinationally so a new block can be
    // loaded on the same edge the finished one leaves.
    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == RUN);
    assign out_block = blk;

    aes_round_sel u_round (
        .state_in  (blk),
        .round_key (round_key),
        .last      (last_round),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d = fsm;
        rnd_d = rnd;
        blk_d = blk;
        case (fsm)
            IDLE, DONE: begin
                if (accept) begin
                    fsm_d = RUN;
                    rnd_d = 4'd1;
                    blk_d = add_round_key(in_block, key_slice(keys, 4'd0));
                end else if (fsm == DONE && out_ready) begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                blk_d = round_out;
                if (last_round) fsm_d = DONE;
                else            rnd_d = rnd + 4'd1;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            rnd <= '0;
            blk <= '0;
        end else begin
            fsm <= fsm_d;
            rnd <= rnd_d;
            blk <= blk_d;
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
module tb_aes_cipher_iter;

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst;
    logic         in_valid[3];
    logic         in_ready[3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic         busy[3];
    logic [127:0] in_block[3];
    logic [127:0] out_block[3];
    logic [128*11-1:0] w4;
    logic [128*13-1:0] w6;
    logic [128*15-1:0] w8;
    logic [1919:0] ks_a, ks_b, ks_192, ks_256;
    logic [7:0]    sbox_t[256];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_cipher_iter #(.NK(4)) u_aes128 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_block(in_block[0]), .w(w4), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_block(out_block[0]), .busy(busy[0]));
    aes_cipher_iter #(.NK(6)) u_aes192 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_block(in_block[1]), .w(w6), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_block(out_block[1]), .busy(busy[1]));
    aes_cipher_iter #(.NK(8)) u_aes256 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_block(in_block[2]), .w(w8), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_block(out_block[2]), .busy(busy[2]));

    // Key schedule generation: field multiply by shift-and-add, inverse by
    // exhaustive search, affine map written bitwise.
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0]   wd[60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        int total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        res = '0;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) res[1919-32*i -: 32] = wd[i];
        return res;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_block[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]); end
            checks++;
            if (out_block[k] !== 128'h0) begin errors++; $display("FAIL reset_out_block[%0d]: got %h expected 0", k, out_block[k]); end
            checks++;
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
            checks++;
            if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]); end
        end
    endtask

    task automatic test_fips_vector(input int k, input logic [127:0] pt,
                                    input logic [127:0] exp_ct, input int exp_lat);
        int lat;
        @(negedge clk);
        in_block[k] = pt; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
        checks++;
        if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b expected 1", k, in_ready[k]); end
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        checks++;
        if (busy[k] !== 1'b1) begin errors++; $display("FAIL vec%0d_busy: got %b expected 1", k, busy[k]); end
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", k, lat, exp_lat); end
        checks++;
        if (out_block[k] !== exp_ct) begin errors++; $display("FAIL vec%0d_ciphertext: got %h expected %h", k, out_block[k], exp_ct); end
        out_ready[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[k] = 1'b0;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            errors++; $display("FAIL vec%0d_pop: got out_valid=%b in_ready=%b expected 0 1", k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        @(negedge clk);
        in_block[0] = PT_C; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        checks++;
        if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", out_valid[0]); end
        in_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1 || out_block[0] !== CT_128) begin
                errors++; $display("FAIL bp_hold cycle %0d: got valid=%b block=%h expected 1 %h", c, out_valid[0], out_block[0], CT_128);
            end
            checks++;
            if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++; $display("FAIL bp_no_accept cycle %0d: got in_ready=%b busy=%b expected 0 0", c, in_ready[0], busy[0]);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL bp_release_accept: got busy=%b out_valid=%b expected 1 0", busy[0], out_valid[0]);
        end
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        checks++;
        if (lat != 10 || out_block[0] !== CT_128) begin
            errors++; $display("FAIL bp_second_block: got lat=%0d block=%h expected 10 %h", lat, out_block[0], CT_128);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0]  pts[3];
        logic [127:0]  cts[3];
        logic [1919:0] kss[3];
        int            acc_edge[$];
        logic [127:0]  got[$];
        int            nxt;
        pts[0] = PT_C; cts[0] = CT_128; kss[0] = ks_a;
        pts[1] = PT_B; cts[1] = CT_B;   kss[1] = ks_b;
        pts[2] = PT_C; cts[2] = CT_128; kss[2] = ks_a;
        @(negedge clk);
        out_ready[0] = 1'b1;
        in_block[0]  = pts[0];
        w4           = kss[0][1919 -: 128*11];
        in_valid[0]  = 1'b1;
        nxt = 1;
        for (int e = 0; e < 60 && got.size() < 3; e++) begin
            if (out_valid[0] === 1'b1) begin
                got.push_back(out_block[0]);
                if (nxt < 3) begin
                    in_block[0] = pts[nxt];
                    w4 = kss[nxt][1919 -: 128*11];
                    nxt++;
                end else begin
                    in_valid[0] = 1'b0;
                end
            end
            if (in_valid[0] === 1'b1 && in_ready[0] === 1'b1) acc_edge.push_back(e);
            @(posedge clk); @(negedge clk);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        checks++;
        if (acc_edge.size() != 3) begin errors++; $display("FAIL b2b_accept_count: got %0d expected 3", acc_edge.size()); end
        checks++;
        if (got.size() != 3) begin errors++; $display("FAIL b2b_output_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_edge.size() || acc_edge[i] != 11 * i) begin
                errors++; $display("FAIL b2b_accept_edge[%0d]: got %0d expected %0d", i, (i < acc_edge.size()) ? acc_edge[i] : -1, 11 * i);
            end
            checks++;
            if (i >= got.size() || got[i] !== cts[i]) begin
                errors++; $display("FAIL b2b_output[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 128'h0, cts[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        @(negedge clk);
        in_block[0] = PT_C; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready[0]); end
        checks++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b out_valid=%b expected 0 0", busy[0], out_valid[0]);
        end
        checks++;
        if (out_block[0] !== 128'h0) begin errors++; $display("FAIL abort_out_block: got %h expected 0", out_block[0]); end
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_output: got %b expected 0", seen); end
        out_ready[0] = 1'b0;
        test_fips_vector(0, PT_C, CT_128, 10);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_block[k] = '0;
        end
        build_sbox();
        ks_a   = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        ks_b   = expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        ks_192 = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        ks_256 = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        w4 = ks_a[1919 -: 128*11];
        w6 = ks_192[1919 -: 128*13];
        w8 = ks_256;
        test_reset();
        test_fips_vector(0, PT_C, CT_128, 10);
        test_fips_vector(1, PT_C, CT_192, 12);
        test_fips_vector(2, PT_C, CT_256, 14);
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
